// File: rtl/uart_sys_defs.sv
// rtl/uart_sys_defs.sv - shared opcodes, widths and state encodings for the UART command path
package uart_sys_defs;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int ALU_OUT_W = 16;

  localparam logic [DATA_W-1:0] CMD_RF_WR   = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_RF_RD   = 8'hBB;
  localparam logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [ADDR_W-1:0] OPA_ADDR = 4'd0;
  localparam logic [ADDR_W-1:0] OPB_ADDR = 4'd1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
    ST_OPA, ST_OPB, ST_FUN, ST_ALU_WAIT, ST_TX
  } ctrl_state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_ACK, TX_DONE} tx_state_e;

endpackage

// File: rtl/cmd_tx_serializer.sv
// rtl/cmd_tx_serializer.sv - sends a 1- or 2-byte response LSB first using the TX busy handshake
module cmd_tx_serializer
  import uart_sys_defs::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ALU_OUT_W-1:0] word,
  input  logic [1:0]           count,
  input  logic                 tx_busy,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_vld,
  output logic                 done
);

  tx_state_e            state;
  logic [ALU_OUT_W-1:0] shreg;
  logic [1:0]           cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
      done    <= 1'b0;
    end else begin
      tx_vld <= 1'b0;
      done   <= 1'b0;
      case (state)
        TX_IDLE: if (start) begin
          shreg <= word;
          cnt   <= count;
          state <= TX_SEND;
        end
        TX_SEND: if (!tx_busy) begin
          tx_vld  <= 1'b1;
          tx_data <= shreg[DATA_W-1:0];
          shreg   <= {{DATA_W{1'b0}}, shreg[ALU_OUT_W-1:DATA_W]};
          state   <= TX_ACK;
        end
        // Wait for the transmitter to acknowledge by raising busy before watching it fall.
        TX_ACK: if (tx_busy) state <= TX_DONE;
        TX_DONE: if (!tx_busy) begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            done  <= 1'b1;
            state <= TX_IDLE;
          end else begin
            state <= TX_SEND;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - decodes framed UART commands into RF/ALU operations and returns results
module uart_cmd_ctrl
  import uart_sys_defs::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [ADDR_W-1:0]    RF_Address,
  output logic [DATA_W-1:0]    RF_WrData,
  output logic                 RF_WrEn,
  output logic                 RF_RdEn,
  input  logic [DATA_W-1:0]    RF_RdData,
  input  logic                 RF_RdData_VLD,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_GATE_EN,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_BUSY,
  output logic                 CMD_ERR
);

  ctrl_state_e          state;
  logic [ADDR_W-1:0]    addr_q;
  logic                 tx_start;
  logic [ALU_OUT_W-1:0] tx_word;
  logic [1:0]           tx_count;
  logic                 tx_done;

  always_comb begin
    tx_start = 1'b0;
    tx_word  = '0;
    tx_count = 2'd2;
    if (state == ST_RD_WAIT) begin
      tx_start = RF_RdData_VLD;
      tx_word  = {{(ALU_OUT_W-DATA_W){1'b0}}, RF_RdData};
      tx_count = 2'd1;
    end else if (state == ST_ALU_WAIT) begin
      tx_start = ALU_OUT_VLD;
      tx_word  = ALU_OUT;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;
      case (state)
        ST_IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:   state <= ST_WR_ADDR;
            CMD_RF_RD:   state <= ST_RD_ADDR;
            CMD_ALU_OP:  state <= ST_OPA;
            CMD_ALU_NOP: state <= ST_FUN;
            default:     CMD_ERR <= 1'b1;
          endcase
        end
        ST_WR_ADDR: if (RX_D_VLD) begin
          addr_q <= RX_P_DATA[ADDR_W-1:0];
          state  <= ST_WR_DATA;
        end
        ST_WR_DATA: if (RX_D_VLD) begin
          RF_Address <= addr_q;
          RF_WrData  <= RX_P_DATA;
          RF_WrEn    <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_RD_ADDR: if (RX_D_VLD) begin
          RF_Address <= RX_P_DATA[ADDR_W-1:0];
          RF_RdEn    <= 1'b1;
          state      <= ST_RD_WAIT;
        end
        ST_OPA: if (RX_D_VLD) begin
          RF_Address <= OPA_ADDR;
          RF_WrData  <= RX_P_DATA;
          RF_WrEn    <= 1'b1;
          state      <= ST_OPB;
        end
        ST_OPB: if (RX_D_VLD) begin
          RF_Address <= OPB_ADDR;
          RF_WrData  <= RX_P_DATA;
          RF_WrEn    <= 1'b1;
          state      <= ST_FUN;
        end
        ST_FUN: if (RX_D_VLD) begin
          ALU_FUN     <= RX_P_DATA[3:0];
          ALU_EN      <= 1'b1;
          CLK_GATE_EN <= 1'b1;
          state       <= ST_ALU_WAIT;
        end
        // Bytes arriving while a response is pending are dropped, not queued.
        ST_RD_WAIT: begin
          CMD_ERR <= RX_D_VLD;
          if (RF_RdData_VLD) state <= ST_TX;
        end
        ST_ALU_WAIT: begin
          CMD_ERR <= RX_D_VLD;
          if (ALU_OUT_VLD) begin
            CLK_GATE_EN <= 1'b0;
            state       <= ST_TX;
          end
        end
        ST_TX: begin
          CMD_ERR <= RX_D_VLD;
          if (tx_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cmd_tx_serializer u_tx (
    .clk     (CLK),
    .rst     (RST),
    .start   (tx_start),
    .word    (tx_word),
    .count   (tx_count),
    .tx_busy (TX_BUSY),
    .tx_data (TX_P_DATA),
    .tx_vld  (TX_D_VLD),
    .done    (tx_done)
  );

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command controller sitting directly downstream of the UART receiver in the REF_CLK domain. It consumes received bytes (RX_P_DATA/RX_D_VLD, already synchronised) and decodes the framed command protocol. It issues register-file writes and reads and ALU operations. It returns read data and ALU results as bytes to the UART transmitter path with a busy handshake.

Parameters:
DATA_W, 8, UART byte / RF data width
ADDR_W, 4, RF address width
ALU_OUT_W, 16, ALU result width (sent as 2 bytes)
CMD_RF_WR, 8'hAA, RF write command
CMD_RF_RD, 8'hBB, RF read command
CMD_ALU_OP, 8'hCC, ALU with operands command
CMD_ALU_NOP, 8'hDD, ALU without operands command

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_W  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RF_Address  out  ADDR_W  RF address
RF_WrData  out  DATA_W  RF write data
RF_WrEn  out  1  RF write strobe, 1 cycle
RF_RdEn  out  1  RF read strobe, 1 cycle
RF_RdData  in  DATA_W  RF read data
RF_RdData_VLD  in  1  RF read data valid
ALU_FUN  out  4  ALU function select
ALU_EN  out  1  ALU enable, 1 cycle
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  ALU_OUT_W  ALU result
ALU_OUT_VLD  in  1  ALU result valid
TX_P_DATA  out  DATA_W  byte to transmitter
TX_D_VLD  out  1  one-cycle transmit strobe
TX_BUSY  in  1  transmitter busy (synchronised)
CMD_ERR  out  1  one-cycle pulse: byte dropped/unknown

Behaviour:
- Reset (RST=0, async): state IDLE. All outputs 0. Stored address, operand and result registers are 0.
- Every output is registered. Each strobe is high for exactly 1 CLK cycle.
- IDLE: on RX_D_VLD, decode the byte.
  - AA goes to WR_ADDR.
  - BB goes to RD_ADDR.
  - CC goes to OPA.
  - DD goes to FUN.
  - Any other byte pulses CMD_ERR and stays in IDLE.
- WR_ADDR: on the next byte, store byte[ADDR_W-1:0] and go to WR_DATA.
- WR_DATA: on the next byte, assert RF_WrEn the following cycle with RF_Address=stored address and RF_WrData=byte. Return to IDLE.
- RD_ADDR: on the next byte, assert RF_RdEn the following cycle with RF_Address=byte[ADDR_W-1:0]. Go to RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, latch RF_RdData into the tx buffer, byte count=1. Go to TX_SEND.
- OPA: on the next byte, write it to RF address 0 (RF_WrEn pulse). Go to OPB.
- OPB: on the next byte, write it to RF address 1. Go to FUN.
- FUN: on the next byte, set ALU_FUN=byte[3:0]. Assert CLK_GATE_EN and pulse ALU_EN the following cycle. Go to ALU_WAIT.
  - CLK_GATE_EN stays high from FUN exit until ALU_OUT_VLD is seen.
- ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT, byte count=2, drop CLK_GATE_EN. Go to TX_SEND.
- TX_SEND: when TX_BUSY=0, pulse TX_D_VLD with TX_P_DATA=next byte (LSB byte first). Go to TX_ACK.
- TX_ACK: wait for TX_BUSY=1, then go to TX_DONE.
- TX_DONE: wait for TX_BUSY=0. Decrement the byte count. Go to TX_SEND if the count is nonzero, else IDLE.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_SEND, TX_ACK or TX_DONE: the byte is dropped and CMD_ERR pulses. State is unchanged.
- Mid-frame states (WR_ADDR/WR_DATA/RD_ADDR/OPA/OPB/FUN) wait indefinitely for the next byte. There is no timeout.
- Address truncation: upper byte bits are ignored.
- An RF write at address 0 or 1 via AA is legal and overwrites operands.
- Reset asserted mid-command: immediate return to IDLE. In-flight strobes are deasserted asynchronously and the partial command is discarded.

Decomposition:
- Shared package/header `uart_sys_defs`: command opcodes, state encoding, operand RF addresses (OPA_ADDR=0, OPB_ADDR=1).
- One natural sub-module: `cmd_tx_serializer` (TX_SEND/TX_ACK/TX_DONE handshake plus byte counter). The decode FSM stays in the top of this block.

Test Plan:
- Bytes AA,02,07 -> RF_WrEn one cycle, RF_Address=2, RF_WrData=0x07. Then IDLE. No TX_D_VLD.
- Bytes CC,05,03,01 -> RF writes (0,0x05) and (1,0x03). Then ALU_FUN=1, ALU_EN pulse, CLK_GATE_EN high. Model ALU_OUT=0x0002 with VLD -> TX bytes 0x02 then 0x00, each after TX_BUSY low. CLK_GATE_EN drops.
- Bytes BB,02 after the first test -> RF_RdEn with Address=2. Model returns 0x07 -> single TX_D_VLD with TX_P_DATA=0x07.
- Byte 0x55 in IDLE -> CMD_ERR pulse, no other strobes. A following AA,03,09 then executes normally.
- Byte sent during ALU_WAIT -> CMD_ERR, no state change. Hold TX_BUSY=1 for 200 cycles during a 2-byte response -> second byte waits and is sent only after TX_BUSY falls.
- RST low between OPB and FUN -> all outputs 0 immediately. After release, bytes DD,02 -> ALU_EN pulse with ALU_FUN=2.
